fftout_framer: RTL and testbench

- Sits after the pipelined FFT output register and consumes its stream: one result word per i_ce, with i_sync marking bin 0 of each frame. There is no backpressure on this side.
- Collects complete frames into a two-frame ping-pong buffer.
- Replays each frame on a valid/ready interface, with o_last on the final bin, so downstream logic can stall.
- Frames arriving when both buffers are occupied are dropped whole, never partially.

---
 rtl/fftout_framer_if.sv | 34 +++
 rtl/fftout_framer.sv | 143 ++++++++++++++
 tb/tb_fftout_framer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fftout_framer_if.sv
// Bus bundle for fftout_framer: FFT result stream in, valid/ready frame stream out.
// Optional FFTOUT_DROPCNT_EN adds the o_drop_count signal.
interface fftout_framer_if #(
    parameter int unsigned OWIDTH = 21
);
    logic                  i_ce;
    logic [2*OWIDTH-1:0]   i_result;
    logic                  i_sync;
    logic                  o_valid;
    logic                  i_ready;
    logic [2*OWIDTH-1:0]   o_data;
    logic                  o_last;
    logic                  o_overflow;
    logic                  i_ovf_clr;
`ifdef FFTOUT_DROPCNT_EN
    logic [15:0]           o_drop_count;
`endif

    modport master (
        output i_ce, i_result, i_sync, i_ready, i_ovf_clr,
        input  o_valid, o_data, o_last, o_overflow
`ifdef FFTOUT_DROPCNT_EN
        , input o_drop_count
`endif
    );

    modport slave (
        input  i_ce, i_result, i_sync, i_ready, i_ovf_clr,
        output o_valid, o_data, o_last, o_overflow
`ifdef FFTOUT_DROPCNT_EN
        , output o_drop_count
`endif
    );
endinterface

// File: rtl/fftout_framer.sv
// Frames the FFT output stream into a ping-pong buffer and replays it on valid/ready.
// Define FFTOUT_DROPCNT_EN to add a saturating drop counter (o_drop_count).
module fftout_framer #(
    parameter int unsigned OWIDTH  = 21,
    parameter int unsigned LGWIDTH = 8
) (
    input logic            i_clk,
    input logic            i_areset_n,
    fftout_framer_if.slave bus
);
    localparam int unsigned DW = 2 * OWIDTH;
    localparam int unsigned N  = 1 << LGWIDTH;
    localparam logic [LGWIDTH-1:0] LAST_BIN = '1;

    typedef enum logic {W_IDLE, W_FILL} wstate_t;

    logic [DW-1:0] mem [2*N];

    wstate_t            w_state, w_state_d;
    logic [LGWIDTH-1:0] waddr, waddr_d;
    logic               wsel, wsel_d;
    logic [LGWIDTH-1:0] wr_bin_c;
    logic               mem_we_c;
    logic [1:0]         set_full_c;
    logic               drop_c;
    logic               resync_c;

    logic [1:0]         full;
    logic               rsel;
    logic [LGWIDTH-1:0] raddr;
    logic               advance_c;
    logic [1:0]         clr_full_c;

    // Writer: next state, RAM write and buffer-complete events
    always_comb begin
        w_state_d  = w_state;
        waddr_d    = waddr;
        wsel_d     = wsel;
        wr_bin_c   = waddr;
        mem_we_c   = 1'b0;
        set_full_c = 2'b00;
        drop_c     = 1'b0;
        resync_c   = 1'b0;
        if (bus.i_ce) begin
            unique case (w_state)
                W_IDLE: begin
                    if (bus.i_sync) begin
                        if (!full[wsel]) begin
                            mem_we_c  = 1'b1;
                            wr_bin_c  = '0;
                            waddr_d   = LGWIDTH'(1);
                            w_state_d = W_FILL;
                        end else begin
                            drop_c = 1'b1;
                        end
                    end
                end
                W_FILL: begin
                    mem_we_c = 1'b1;
                    if (bus.i_sync) begin
                        wr_bin_c = '0;
                        waddr_d  = LGWIDTH'(1);
                        resync_c = 1'b1;
                    end else if (waddr == LAST_BIN) begin
                        set_full_c = wsel ? 2'b10 : 2'b01;
                        wsel_d     = ~wsel;
                        waddr_d    = '0;
                        w_state_d  = W_IDLE;
                    end else begin
                        waddr_d = waddr + LGWIDTH'(1);
                    end
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            w_state <= W_IDLE;
            waddr   <= '0;
            wsel    <= 1'b0;
        end else begin
            w_state <= w_state_d;
            waddr   <= waddr_d;
            wsel    <= wsel_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we_c) mem[{wsel, wr_bin_c}] <= bus.i_result;
    end

    // Reader fetches whenever the output register is empty or being consumed
    always_comb begin
        advance_c  = full[rsel] && (!bus.o_valid || bus.i_ready);
        clr_full_c = 2'b00;
        if (advance_c && (raddr == LAST_BIN)) clr_full_c = rsel ? 2'b10 : 2'b01;
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            full        <= 2'b00;
            rsel        <= 1'b0;
            raddr       <= '0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
            bus.o_last  <= 1'b0;
        end else begin
            full <= (full | set_full_c) & ~clr_full_c;
            if (advance_c) begin
                bus.o_data  <= mem[{rsel, raddr}];
                bus.o_last  <= (raddr == LAST_BIN);
                bus.o_valid <= 1'b1;
                raddr       <= raddr + LGWIDTH'(1);
                if (raddr == LAST_BIN) rsel <= ~rsel;
            end else if (bus.o_valid && bus.i_ready) begin
                bus.o_valid <= 1'b0;
                bus.o_last  <= 1'b0;
            end
        end
    end

    // Sticky overflow: a drop on the same edge as a clear wins
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n)                bus.o_overflow <= 1'b0;
        else if (drop_c || resync_c)    bus.o_overflow <= 1'b1;
        else if (bus.i_ovf_clr)         bus.o_overflow <= 1'b0;
    end

`ifdef FFTOUT_DROPCNT_EN
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            bus.o_drop_count <= '0;
        end else if (drop_c || resync_c) begin
            if (bus.i_ovf_clr)                     bus.o_drop_count <= 16'd1;
            else if (bus.o_drop_count != 16'hFFFF) bus.o_drop_count <= bus.o_drop_count + 16'd1;
        end else if (bus.i_ovf_clr) begin
            bus.o_drop_count <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_fftout_framer.sv
// Self-checking bench for fftout_framer: directed scenarios plus randomized frames,
// scored against a frame-level queue model. Honours FFTOUT_DROPCNT_EN if defined.
module tb_fftout_framer;
    localparam int unsigned OWIDTH  = 21;
    localparam int unsigned LGWIDTH = 8;
    localparam int unsigned N       = 1 << LGWIDTH;
    localparam int unsigned DW      = 2 * OWIDTH;

    logic i_clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    fftout_framer_if #(.OWIDTH(OWIDTH)) bus ();

    fftout_framer #(.OWIDTH(OWIDTH), .LGWIDTH(LGWIDTH)) dut (
        .i_clk      (i_clk),
        .i_areset_n (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;            // 0 high, 1 low, 2 toggle, 3 random
    logic [DW:0]   exp_q [$];      // {last, data} in expected output order
    logic [DW-1:0] frame [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Downstream ready pattern generator
    initial begin
        bus.i_ready = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                0:       bus.i_ready = 1'b1;
                1:       bus.i_ready = 1'b0;
                2:       bus.i_ready = ~bus.i_ready;
                default: bus.i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Output scoreboard plus hold-while-stalled check
    logic          stall_q = 1'b0;
    logic [DW-1:0] stall_d;
    logic          stall_l;
    always @(negedge i_clk) begin
        logic [DW:0] e;
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 64'(bus.o_valid), 64'(1));
                check("stall_data", 64'(bus.o_data), 64'(stall_d));
                check("stall_last", 64'(bus.o_last), 64'(stall_l));
            end
            if (bus.o_valid && bus.i_ready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_output observed=%0h expected=no_word", bus.o_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("out_data", 64'(bus.o_data), 64'(e[DW-1:0]));
                    check("out_last", 64'(bus.o_last), 64'(e[DW]));
                end
            end
            stall_q = bus.o_valid && !bus.i_ready;
            stall_d = bus.o_data;
            stall_l = bus.o_last;
        end
    end

    task automatic push(input logic s, input logic [DW-1:0] d);
        bus.i_ce     = 1'b1;
        bus.i_sync   = s;
        bus.i_result = d;
        @(posedge i_clk);
        #1;
        bus.i_ce     = 1'b0;
        bus.i_sync   = 1'b0;
        bus.i_result = DW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Sends frame[] with random ce gaps; an accepted frame becomes expected output
    task automatic send_frame(input int gap_max, input logic accept);
        for (int i = 0; i < int'(N); i++) begin
            if (gap_max > 0) idle(int'($urandom_range(0, gap_max)));
            push(i == 0, frame[i]);
        end
        if (accept)
            for (int i = 0; i < int'(N); i++) exp_q.push_back({i == int'(N) - 1, frame[i]});
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 20000) begin
            @(posedge i_clk);
            k++;
        end
        idle(8);
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    // At most one frame outstanding keeps a buffer free for the next sync
    task automatic wait_room();
        int k = 0;
        while (exp_q.size() > N && k < 20000) begin
            @(posedge i_clk);
            k++;
        end
        #1;
        check("room_timeout", 64'(exp_q.size() > N), 64'(0));
    endtask

    task automatic ovf_clear();
        bus.i_ovf_clr = 1'b1;
        @(posedge i_clk);
        #1;
        bus.i_ovf_clr = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bus.i_ce = 1'b0; bus.i_sync = 1'b0; bus.i_result = '0; bus.i_ovf_clr = 1'b0;
        ready_mode = 0;
        idle(3);
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_last", 64'(bus.o_last), 64'(0));
        check("rst_data", 64'(bus.o_data), 64'(0));
        check("rst_ovf", 64'(bus.o_overflow), 64'(0));
`ifdef FFTOUT_DROPCNT_EN
        check("rst_dropcnt", 64'(bus.o_drop_count), 64'(0));
`endif
        rst_n = 1'b1;
        idle(2);

        // Single frame: latency and bubble-free streaming
        for (int i = 0; i < int'(N); i++) frame[i] = DW'(i);
        send_frame(0, 1'b1);
        @(negedge i_clk);
        check("lat_early_valid", 64'(bus.o_valid), 64'(0));
        for (int i = 0; i < int'(N); i++) begin
            @(negedge i_clk);
            check("stream_valid", 64'(bus.o_valid), 64'(1));
            check("stream_data", 64'(bus.o_data), 64'(i));
            check("stream_last", 64'(bus.o_last), 64'(i == int'(N) - 1));
        end
        @(posedge i_clk); #1;
        wait_drain("single_drain");

        // Backpressure: ready toggles every cycle
        ready_mode = 2;
        send_frame(0, 1'b1);
        wait_drain("bp_drain");

        // Overflow: three back-to-back frames with ready low, third dropped
        ready_mode = 1;
        idle(2);
        for (int f = 1; f <= 2; f++) begin
            for (int i = 0; i < int'(N); i++) frame[i] = DW'((f << 8) | i);
            send_frame(0, 1'b1);
        end
        check("ovf_before_third", 64'(bus.o_overflow), 64'(0));
        for (int i = 0; i < int'(N); i++) begin
            push(i == 0, DW'(32'h300 | i));
            if (i == 0) check("ovf_after_third_sync", 64'(bus.o_overflow), 64'(1));
        end
`ifdef FFTOUT_DROPCNT_EN
        check("ovf_dropcnt", 64'(bus.o_drop_count), 64'(1));
`endif
        ready_mode = 0;
        wait_drain("ovf_drain");
        check("ovf_sticky", 64'(bus.o_overflow), 64'(1));
        ovf_clear();
        check("ovf_cleared", 64'(bus.o_overflow), 64'(0));
`ifdef FFTOUT_DROPCNT_EN
        check("dropcnt_cleared", 64'(bus.o_drop_count), 64'(0));
`endif

        // Early resync at bin 100, then a complete frame
        for (int i = 0; i < 100; i++) push(i == 0, DW'(32'h500 | i));
        for (int i = 0; i < int'(N); i++) frame[i] = DW'(32'h600 | i);
        send_frame(0, 1'b1);
        check("resync_ovf", 64'(bus.o_overflow), 64'(1));
`ifdef FFTOUT_DROPCNT_EN
        check("resync_dropcnt", 64'(bus.o_drop_count), 64'(1));
`endif
        wait_drain("resync_drain");
        ovf_clear();
        check("resync_ovf_clr", 64'(bus.o_overflow), 64'(0));

        // Randomized frames, gaps and downstream stalls
        ready_mode = 3;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < int'(N); i++) frame[i] = DW'({$urandom, $urandom});
            wait_room();
            send_frame((f % 2) * 2, 1'b1);
        end
        ready_mode = 0;
        wait_drain("rand_drain");
        check("rand_no_ovf", 64'(bus.o_overflow), 64'(0));

        // Pre-sync garbage is ignored
        for (int i = 0; i < 37; i++) push(1'b0, DW'({$urandom, $urandom}));
        for (int i = 0; i < int'(N); i++) frame[i] = DW'(32'h800 | i);
        send_frame(0, 1'b1);
        wait_drain("garbage_drain");
        check("garbage_no_ovf", 64'(bus.o_overflow), 64'(0));

        // Reset during readout of bin 50
        for (int i = 0; i < int'(N); i++) frame[i] = DW'(32'h700 | i);
        send_frame(0, 1'b1);
        k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!(bus.o_valid && bus.o_data == frame[50]) && k < 2000);
        check("rst_mid_reached", 64'(k < 2000), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(bus.o_valid), 64'(0));
        check("rst_mid_last", 64'(bus.o_last), 64'(0));
        check("rst_mid_data", 64'(bus.o_data), 64'(0));
        exp_q.delete();
        @(posedge i_clk); #1;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        for (int i = 0; i < int'(N); i++) frame[i] = DW'(32'h900 | i);
        send_frame(0, 1'b1);
        wait_drain("post_rst_drain");
        check("post_rst_no_ovf", 64'(bus.o_overflow), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
